// File: rtl/i2s_sample_tx.sv
// I2S transmitter: takes stereo sample pairs over valid/ready and shifts them out
// as BCLK/LRCLK/SDATA derived from clk, with a per-frame strobe and underrun flag.
module i2s_sample_tx #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] sample_l,
    input  logic [BITS-1:0] sample_r,
    input  logic            sample_valid,
    output logic            sample_ready,
    output logic            frame_start,
    output logic            underrun,
    output logic            i2s_bclk,
    output logic            i2s_lrclk,
    output logic            i2s_sdata
);

    localparam int unsigned FW    = 2 * BITS;
    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(FW);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t        buf_state;
    buf_state_t        buf_state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [FW-1:0]     frame_word;
    logic [FW-1:0]     buf_word;
    logic [FW-1:0]     last_word;

    logic              div_wrap_c;
    logic              fall_c;
    logic              load_c;
    logic              accept_c;
    logic [IDX_W-1:0]  idx_next_c;
    logic [IDX_W-1:0]  sel_c;

    // BCLK falls when the divider wraps while BCLK is high; the frame reloads when bit_idx wraps
    assign div_wrap_c = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall_c     = div_wrap_c && i2s_bclk;
    assign idx_next_c = (bit_idx == IDX_W'(FW - 1)) ? '0 : bit_idx + IDX_W'(1);
    assign load_c     = fall_c && (idx_next_c == '0);
    assign accept_c   = sample_valid && (buf_state == BUF_EMPTY);
    // Slot k carries frame bit FW-k, giving the one-BCLK I2S delay behind LRCLK
    assign sel_c      = IDX_W'(FW - 32'(idx_next_c));

    always_comb begin
        buf_state_nxt = buf_state;
        case (buf_state)
            BUF_EMPTY: if (accept_c) buf_state_nxt = BUF_FULL;
            BUF_FULL:  if (load_c)   buf_state_nxt = BUF_EMPTY;
            default:   buf_state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_state <= BUF_EMPTY;
        end else begin
            buf_state <= buf_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            bit_idx      <= IDX_W'(FW - 1);
            frame_word   <= '0;
            buf_word     <= '0;
            last_word    <= '0;
            sample_ready <= 1'b1;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            i2s_bclk     <= 1'b0;
            i2s_lrclk    <= 1'b1;
            i2s_sdata    <= 1'b0;
        end else begin
            div_cnt      <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
            sample_ready <= (buf_state_nxt == BUF_EMPTY);
            frame_start  <= load_c;
            underrun     <= load_c && (buf_state == BUF_EMPTY);

            if (div_wrap_c) begin
                i2s_bclk <= ~i2s_bclk;
            end

            if (accept_c) begin
                buf_word <= {sample_l, sample_r};
            end

            if (fall_c) begin
                bit_idx   <= idx_next_c;
                i2s_lrclk <= (idx_next_c >= IDX_W'(BITS));
                if (load_c) begin
                    // Slot 0 still carries the outgoing frame's right LSB
                    i2s_sdata <= frame_word[0];
                    if (buf_state == BUF_FULL) begin
                        frame_word <= buf_word;
                        last_word  <= buf_word;
                    end else begin
                        frame_word <= last_word;
                    end
                end else begin
                    i2s_sdata <= frame_word[sel_c];
                end
            end
        end
    end

endmodule
